// File: rtl/uart_rx_os16.sv
// uart_rx_os16 -- 16x oversampling UART receiver.
//
// Recovers one asynchronous serial frame (start bit, dataBits data bits sent
// LSB first, stop bit) from rx, using sTick as a 16x-baud sampling enable.
// The start bit is checked at its middle (tick 7), each data bit is sampled
// 16 ticks later, and the stop bit is sampled sbTick ticks after the last
// data bit.
//
// Parameters:
//   dataBits   data bits per frame (must be >= 2)
//   sbTick     sTick pulses in the stop bit (16 = one stop bit)
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-low reset
//   sTick      one-clk oversampling enable, 16 per bit period
//   rx         asynchronous serial line, idles high
//   dout       last received data word
//   rxDoneTick one-clk strobe, high in the clk in which dout is updated
//   frameErr   1 when the stop bit of the last completed frame was low
module uart_rx_os16 #(
    parameter int dataBits = 8,
    parameter int sbTick   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sTick,
    input  logic                rx,
    output logic [dataBits-1:0] dout,
    output logic                rxDoneTick,
    output logic                frameErr
);

    localparam int NW = (dataBits > 1) ? $clog2(dataBits) : 1;
    localparam logic [3:0]    S_MID     = 4'd7;
    localparam logic [3:0]    S_LAST    = 4'd15;
    localparam logic [3:0]    S_STOP    = 4'(sbTick - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(dataBits - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           s_q, s_d;
    logic [NW-1:0]        n_q, n_d;
    logic [dataBits-1:0]  b_q, b_d;
    logic [dataBits-1:0]  dout_q, dout_d;
    logic                 frameErr_q, frameErr_d;
    logic                 done_q, done_d;
    logic                 sync1_q, sync2_q;
    logic                 rxS;

    // Two-flop synchronizer; resets to the idle line level so a reset never
    // looks like a falling edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rxS = sync2_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            b_q        <= '0;
            dout_q     <= '0;
            frameErr_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            b_q        <= b_d;
            dout_q     <= dout_d;
            frameErr_q <= frameErr_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        b_d        = b_q;
        dout_d     = dout_q;
        frameErr_d = frameErr_q;
        done_d     = 1'b0;

        unique case (state_q)
            // Edge detection runs every clk, not only on sTick, so the start
            // bit phase is measured from the synchronized falling edge.
            IDLE: begin
                if (!rxS) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (sTick) begin
                    if (s_q == S_MID) begin
                        if (!rxS) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            // Line went back high by mid-bit: a glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (sTick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rxS, b_q[dataBits-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (sTick) begin
                    if (s_q == S_STOP) begin
                        // A low stop bit still delivers the word, flagged.
                        state_d    = IDLE;
                        dout_d     = b_q;
                        frameErr_d = ~rxS;
                        done_d     = 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout       = dout_q;
    assign frameErr   = frameErr_q;
    assign rxDoneTick = done_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
module tb_uart_rx_os16;

    logic       clk;
    logic       reset;
    logic       sTick;
    logic       rx;
    logic [7:0] dout;
    logic       rxDoneTick;
    logic       frameErr;

    uart_rx_os16 #(.dataBits(8), .sbTick(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .sTick      (sTick),
        .rx         (rx),
        .dout       (dout),
        .rxDoneTick (rxDoneTick),
        .frameErr   (frameErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int pulses = 0;
    logic tick_en = 1'b0;
    logic [8:0] exp_q[$];   // {frameErr, dout}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // sTick every 4th clk; the phase counter keeps running while gated so
    // the tick grid stays aligned with the 64-clk bit grid.
    initial begin
        int cnt = 0;
        sTick = 1'b0;
        forever begin
            @(negedge clk);
            cnt = (cnt + 1) % 4;
            sTick = tick_en && (cnt == 3);
        end
    end

    // Monitor: every strobe pops the next expected frame.
    initial begin
        logic prev = 1'b0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rxDoneTick) begin
                pulses++;
                chk("single_clk_pulse", {31'd0, prev}, 32'd0);
                chk("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("dout", {24'd0, dout}, {24'd0, e[7:0]});
                    chk("frameErr", {31'd0, frameErr}, {31'd0, e[8]});
                end
            end
            prev = rxDoneTick;
        end
    end

    // Sends one 640-clk frame. A low stop bit is held only for the first 40
    // clks so that the line is back high before a re-entered start bit would
    // be checked. rst_at pulses reset at that clk and abandons the frame;
    // pause_at gates sTick and freezes the line for 200 clks.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int rst_at, input int pause_at);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int c = 0; c < 640; c++) begin
            @(negedge clk);
            rx = bits[c / 64];
            if (c / 64 == 9 && !stop_bit && (c % 64) >= 40) rx = 1'b1;
            if (c == rst_at) begin
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                rx    = 1'b1;
                return;
            end
            if (c == pause_at) begin
                tick_en = 1'b0;
                repeat (200) @(negedge clk);
                tick_en = 1'b1;
            end
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0;
        reset = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_dout", {24'd0, dout}, 32'd0);
        chk("reset_done", {31'd0, rxDoneTick}, 32'd0);
        chk("reset_frameErr", {31'd0, frameErr}, 32'd0);
        reset   = 1'b1;
        tick_en = 1'b1;
        gap(100);

        // Basic frame
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, -1, -1);
        gap(128);
        chk("a5_pulse_count", pulses, 32'd1);

        // 12-clk glitch: false start, nothing delivered
        p0 = pulses;
        @(negedge clk); rx = 1'b0;
        gap(12);
        rx = 1'b1;
        gap(200);
        chk("glitch_no_pulse", pulses, p0);
        chk("glitch_dout_held", {24'd0, dout}, 32'hA5);

        // Framing error, then recovery
        exp_q.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 1'b0, -1, -1);
        gap(128);
        chk("ferr_frameErr_held", {31'd0, frameErr}, 32'd1);
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1, -1, -1);
        gap(128);

        // Back-to-back frames with no idle gap
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        gap(128);

        // Reset during data bit 3 (frame bit 4) of 0x55
        p0 = pulses;
        send_frame(8'h55, 1'b1, 4 * 64 + 20, -1);
        gap(800);
        chk("rst_no_pulse", pulses, p0);
        chk("rst_dout_cleared", {24'd0, dout}, 32'd0);
        chk("rst_frameErr_cleared", {31'd0, frameErr}, 32'd0);
        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h55, 1'b1, -1, -1);
        gap(128);

        // sTick gated for 200 clks during data bit 4
        exp_q.push_back({1'b0, 8'h96});
        send_frame(8'h96, 1'b1, -1, 5 * 64 + 20);
        gap(200);

        chk("all_frames_delivered", exp_q.size(), 32'd0);
        chk("total_pulses", pulses, 32'd7);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Hard bound on run time in case the stimulus stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: sim time %0t exceeded limit", $time);
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
